// File: rtl/piso_baud_tx_if.sv
// Frame-request / serial-line bundle between a parallel producer and piso_baud_tx.
// master drives start/din and observes the line; slave is the transmitter itself.
interface piso_baud_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] din;
  logic              dout;
  logic              busy;
  logic              done;

  modport master (output start, din, input dout, busy, done);
  modport slave  (input start, din, output dout, busy, done);
endinterface

// File: rtl/piso_baud_tx.sv
// Parallel-in serial-out UART-style transmitter: start bit, DATA_W data bits,
// optional parity, STOP_BITS stop bits; each bit held for BAUD_DIV clocks, line registered.
module piso_baud_tx #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int MSB_FIRST  = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  piso_baud_tx_if.slave    bus
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              stop_q, stop_d;
  logic              dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              baud_wrap;
  logic [DATA_W-1:0] shreg_shift;

  assign baud_wrap   = (baud_q == CNT_W'(BAUD_DIV - 1));
  assign shreg_shift = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      dout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // dout_d is the level for the cycle after this edge, so every bit
  // transition is decided one cycle early and the line stays registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_wrap ? '0 : baud_q + CNT_W'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    stop_d  = stop_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        dout_d = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          shreg_d = bus.din;
          par_d   = (^bus.din) ^ (PARITY_ODD != 0);
          idx_d   = '0;
          stop_d  = 1'b0;
          dout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          dout_d  = head_bit(shreg_q);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          shreg_d = shreg_shift;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            if (PARITY_EN != 0) begin
              dout_d  = par_q;
              state_d = S_PARITY;
            end else begin
              dout_d  = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            dout_d = head_bit(shreg_shift);
          end
        end
      end
      S_PARITY: begin
        if (baud_wrap) begin
          dout_d  = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            dout_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        dout_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_piso_baud_tx.sv
// Five transmitter configurations share one start/din stimulus; a per-instance
// cycle-level scoreboard predicts dout, busy and done on every clock.
module tb_piso_baud_tx;

  localparam int NI = 5;
  localparam int P_BD  [NI] = '{4, 4, 4, 4, 1};
  localparam int P_PE  [NI] = '{0, 1, 1, 0, 1};
  localparam int P_PO  [NI] = '{0, 0, 1, 0, 1};
  localparam int P_MSB [NI] = '{0, 0, 0, 1, 1};
  localparam int P_SB  [NI] = '{1, 1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;

  logic [NI-1:0] dout_v, busy_v, done_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    piso_baud_tx_if #(.DATA_W(8)) u_if ();
    assign u_if.start = start;
    assign u_if.din   = din;
    assign dout_v[g]  = u_if.dout;
    assign busy_v[g]  = u_if.busy;
    assign done_v[g]  = u_if.done;

    piso_baud_tx #(
      .DATA_W    (8),
      .BAUD_DIV  (P_BD[g]),
      .PARITY_EN (P_PE[g]),
      .PARITY_ODD(P_PO[g]),
      .MSB_FIRST (P_MSB[g]),
      .STOP_BITS (P_SB[g])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
    );
  end

  bit exp_q [NI][$];
  int rem      [NI];
  bit done_exp [NI];
  int done_cnt [NI];
  int busy_len [NI];
  int last_len [NI];
  int base_cnt [NI];
  int n_cmp = 0;
  int n_err = 0;

  function automatic int frame_len(input int i);
    return (1 + 8 + P_PE[i] + P_SB[i]) * P_BD[i];
  endfunction

  function automatic void push_frame(input int i, input logic [7:0] d);
    bit seq [$];
    seq.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      seq.push_back((P_MSB[i] != 0) ? d[7-k] : d[k]);
    if (P_PE[i] != 0)
      seq.push_back((^d) ^ (P_PO[i] != 0));
    for (int k = 0; k < P_SB[i]; k++)
      seq.push_back(1'b1);
    foreach (seq[k])
      for (int r = 0; r < P_BD[i]; r++)
        exp_q[i].push_back(seq[k]);
  endfunction

  // Acceptance model: a frame starts at an edge where start=1 and the
  // previous frame's last cycle has already elapsed.
  initial begin : model
    for (int i = 0; i < NI; i++) rem[i] = 0;
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          exp_q[i].delete();
          rem[i] = 0;
        end else if (rem[i] == 0) begin
          if (start === 1'b1) begin
            push_frame(i, din);
            rem[i] = frame_len(i);
          end
        end else begin
          rem[i] = rem[i] - 1;
        end
      end
    end
  end

  initial begin : monitor
    bit eb, ebusy;
    for (int i = 0; i < NI; i++) begin
      done_exp[i] = 1'b0; done_cnt[i] = 0; busy_len[i] = 0; last_len[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          done_exp[i] = 1'b0;
          busy_len[i] = 0;
        end
        ebusy = (exp_q[i].size() != 0);
        n_cmp++;
        if (done_v[i] !== done_exp[i]) begin
          n_err++;
          $display("FAIL done[%0d] t=%0t got %b want %b", i, $time, done_v[i], done_exp[i]);
        end
        done_exp[i] = 1'b0;
        n_cmp++;
        if (busy_v[i] !== ebusy) begin
          n_err++;
          $display("FAIL busy[%0d] t=%0t got %b want %b", i, $time, busy_v[i], ebusy);
        end
        eb = ebusy ? exp_q[i].pop_front() : 1'b1;
        if (ebusy && exp_q[i].size() == 0) done_exp[i] = 1'b1;
        n_cmp++;
        if (dout_v[i] !== eb) begin
          n_err++;
          $display("FAIL dout[%0d] t=%0t got %b want %b", i, $time, dout_v[i], eb);
        end
        if (busy_v[i] === 1'b1) busy_len[i]++;
        if (done_v[i] === 1'b1) begin
          last_len[i] = busy_len[i];
          busy_len[i] = 0;
          done_cnt[i]++;
        end
      end
    end
  end

  task automatic wait_all_idle();
    int t = 0;
    while (busy_v != '0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (busy_v != '0) begin
      n_err++;
      $display("FAIL idle_timeout busy=%b want 0", busy_v);
    end
    #1;
  endtask

  task automatic wait_done0();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (done_v[0] !== 1'b1 && t < 200);
    n_cmp++;
    if (done_v[0] !== 1'b1) begin
      n_err++;
      $display("FAIL done0_timeout got %b want 1", done_v[0]);
    end
    #1;
  endtask

  task automatic snap_done();
    for (int i = 0; i < NI; i++) base_cnt[i] = done_cnt[i];
  endtask

  task automatic check_one_frame(input string tag);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (done_cnt[i] - base_cnt[i] != 1) begin
        n_err++;
        $display("FAIL %s done_count[%0d] got %0d want 1", tag, i, done_cnt[i] - base_cnt[i]);
      end
      n_cmp++;
      if (last_len[i] != frame_len(i)) begin
        n_err++;
        $display("FAIL %s length[%0d] got %0d want %0d", tag, i, last_len[i], frame_len(i));
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if (dout_v !== '1) begin n_err++; $display("FAIL reset_dout got %b want all 1", dout_v); end
    n_cmp++;
    if (busy_v !== '0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_v); end
    n_cmp++;
    if (done_v !== '0) begin n_err++; $display("FAIL reset_done got %b want 0", done_v); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Single frame; also samples the parity slot (cycles 36..39) directly.
  task automatic test_frame(input logic [7:0] d, input string tag);
    snap_done();
    @(negedge clk);
    start = 1'b1;
    din   = d;
    @(negedge clk);
    start = 1'b0;
    din   = ~d;
    repeat (37) @(negedge clk);
    n_cmp++;
    if (dout_v[1] !== (^d)) begin
      n_err++;
      $display("FAIL %s even_parity got %b want %b", tag, dout_v[1], ^d);
    end
    n_cmp++;
    if (dout_v[2] !== ~(^d)) begin
      n_err++;
      $display("FAIL %s odd_parity got %b want %b", tag, dout_v[2], ~(^d));
    end
    wait_all_idle();
    check_one_frame(tag);
  endtask

  task automatic test_ignore_busy();
    snap_done();
    @(negedge clk);
    start = 1'b1;
    din   = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    din   = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    din   = 8'h00;
    wait_all_idle();
    repeat (3) @(negedge clk);
    check_one_frame("ignore_busy");
  endtask

  task automatic test_back_to_back();
    int base0;
    base0 = done_cnt[0];
    @(negedge clk);
    start = 1'b1;
    din   = 8'h0F;
    @(negedge clk);
    din = 8'hF0;
    wait_done0();
    @(negedge clk);
    din = 8'h3C;
    wait_done0();
    @(negedge clk);
    start = 1'b0;
    din   = 8'h00;
    wait_done0();
    wait_all_idle();
    n_cmp++;
    if (done_cnt[0] - base0 != 3) begin
      n_err++;
      $display("FAIL back_to_back done_count got %0d want 3", done_cnt[0] - base0);
    end
  endtask

  task automatic test_abort();
    int base0;
    @(negedge clk);
    start = 1'b1;
    din   = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    base0 = done_cnt[0];
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (dout_v[0] !== 1'b1) begin n_err++; $display("FAIL abort_dout got %b want 1", dout_v[0]); end
    n_cmp++;
    if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy_v[0]); end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (done_cnt[0] != base0) begin
      n_err++;
      $display("FAIL abort_no_done got %0d want %0d", done_cnt[0], base0);
    end
    snap_done();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    din   = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    wait_all_idle();
    check_one_frame("after_abort");
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, "frame_a5");
    test_frame(8'h07, "frame_07");
    test_frame(8'h01, "frame_01");
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
